// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute controller for the accumulator computer datapath.
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_COUNT_EN.
//
// state      | meaning
// IDLE       | waiting for start, all outputs low
// FETCH_ADDR | MAR <= PC
// FETCH_MEM  | instruction read, wait for mem_ready
// FETCH_IR   | IR <= MBR, PC <= PC+1
// DECODE     | operand address to MAR, or jump / halt
// OP_RD      | operand read, wait for mem_ready
// EXEC       | ACC <= MBR or ALU result
// OP_WR      | ACC written to M[MAR], wait for mem_ready
// HALTED     | stopped until reset
module accumulator_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] instruction,
  input  logic              acc_zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              write_mar,
  output logic              write_mbr,
  output logic              write_ir,
  output logic              write_pc,
  output logic              write_acc,
  output logic              mar_sel,
  output logic              pc_sel,
  output logic              acc_sel,
  output logic [3:0]        alu_op,
  output logic              halted,
  output logic              illegal
`ifdef SEQ_RETIRE_COUNT_EN
  ,output logic [31:0]      retired_count
`endif
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FETCH_ADDR = 4'd1;
  localparam logic [3:0] S_FETCH_MEM  = 4'd2;
  localparam logic [3:0] S_FETCH_IR   = 4'd3;
  localparam logic [3:0] S_DECODE     = 4'd4;
  localparam logic [3:0] S_OP_RD      = 4'd5;
  localparam logic [3:0] S_EXEC       = 4'd6;
  localparam logic [3:0] S_OP_WR      = 4'd7;
  localparam logic [3:0] S_HALTED     = 4'd8;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'h9;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] opcode;
  logic       is_mem_op;
  logic       is_jump;
  logic       illegal_entry;

  // Operand field is routed by the datapath muxes, never inspected here.
  logic [ADDR_W-1:0] unused_operand;
  assign unused_operand = instruction[ADDR_W-1:0];

  assign opcode    = instruction[DATA_W-1:DATA_W-4];
  assign is_mem_op = (opcode >= OP_LOAD) && (opcode <= OP_OR);
  assign is_jump   = (opcode == OP_JUMP) || (opcode == OP_JZ);
  assign illegal_entry = (state == S_DECODE) && !is_mem_op && !is_jump &&
                         (opcode != OP_HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start) state_nxt = S_FETCH_ADDR;
      S_FETCH_ADDR: state_nxt = S_FETCH_MEM;
      S_FETCH_MEM:  if (mem_ready) state_nxt = S_FETCH_IR;
      S_FETCH_IR:   state_nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_STORE)  state_nxt = S_OP_WR;
        else if (is_mem_op)      state_nxt = S_OP_RD;
        else if (is_jump)        state_nxt = S_FETCH_ADDR;
        else                     state_nxt = S_HALTED;
      end
      S_OP_RD:      if (mem_ready) state_nxt = S_EXEC;
      S_EXEC:       state_nxt = S_FETCH_ADDR;
      S_OP_WR:      if (mem_ready) state_nxt = S_FETCH_ADDR;
      S_HALTED:     state_nxt = S_HALTED;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (illegal_entry) illegal <= 1'b1;
    end
  end

`ifdef SEQ_RETIRE_COUNT_EN
  logic retire;
  assign retire = (state == S_EXEC) ||
                  (state == S_OP_WR && mem_ready) ||
                  (state == S_DECODE && is_jump);

  always_ff @(posedge clock) begin
    if (reset)       retired_count <= 32'd0;
    else if (retire) retired_count <= retired_count + 32'd1;
  end
`endif

  assign halted = (state == S_HALTED);

  // Control outputs are forced low while reset is held so a pending request drops at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    write_mar = 1'b0;
    write_mbr = 1'b0;
    write_ir  = 1'b0;
    write_pc  = 1'b0;
    write_acc = 1'b0;
    mar_sel   = 1'b0;
    pc_sel    = 1'b0;
    acc_sel   = 1'b0;
    alu_op    = 4'b0000;
    if (!reset) begin
      case (state)
        S_FETCH_ADDR: write_mar = 1'b1;
        S_FETCH_MEM: begin
          mem_req   = 1'b1;
          write_mbr = mem_ready;
        end
        S_FETCH_IR: begin
          write_ir = 1'b1;
          write_pc = 1'b1;
        end
        S_DECODE: begin
          if (is_mem_op) begin
            write_mar = 1'b1;
            mar_sel   = 1'b1;
          end else if (opcode == OP_JUMP || (opcode == OP_JZ && acc_zero)) begin
            write_pc = 1'b1;
            pc_sel   = 1'b1;
          end
        end
        S_OP_RD: begin
          mem_req   = 1'b1;
          write_mbr = mem_ready;
        end
        S_EXEC: begin
          write_acc = 1'b1;
          acc_sel   = (opcode != OP_LOAD);
          case (opcode)
            OP_SUB:  alu_op = 4'b0001;
            OP_AND:  alu_op = 4'b1000;
            OP_OR:   alu_op = 4'b1001;
            default: alu_op = 4'b0000;
          endcase
        end
        S_OP_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer: directed scenarios plus random
// stimulus against a phase-level reference model.
module tb_accumulator_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        acc_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, write_mar, write_mbr, write_ir, write_pc, write_acc;
  logic        mar_sel, pc_sel, acc_sel, halted, illegal;
  logic [3:0]  alu_op;
`ifdef SEQ_RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif

  accumulator_sequencer #(.DATA_W(16), .ADDR_W(12)) dut (
    .clock(clock), .reset(reset), .start(start), .instruction(instruction),
    .acc_zero(acc_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .write_mar(write_mar), .write_mbr(write_mbr), .write_ir(write_ir),
    .write_pc(write_pc), .write_acc(write_acc), .mar_sel(mar_sel), .pc_sel(pc_sel),
    .acc_sel(acc_sel), .alu_op(alu_op), .halted(halted), .illegal(illegal)
`ifdef SEQ_RETIRE_COUNT_EN
    , .retired_count(retired_count)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: instruction phase, sticky illegal flag, retired count.
  string       ph = "idle";
  bit          m_ill = 1'b0;
  logic [31:0] m_ret = 32'd0;
  logic [15:0] obs;

  // Bit order: mem_req mem_we wmar wmbr wir wpc wacc mar_sel pc_sel acc_sel alu[3:0] halted illegal
  function automatic logic [15:0] expect_out(bit rst, logic [15:0] ir, bit az, bit rdy);
    bit mreq = 0, mwe = 0, wmar = 0, wmbr = 0, wir = 0, wpc = 0, wacc = 0;
    bit msel = 0, psel = 0, asel = 0;
    logic [3:0] alu = 4'd0;
    int op = int'(ir[15:12]);
    if (!rst) begin
      if (ph == "fa") wmar = 1;
      else if (ph == "fm") begin mreq = 1; wmbr = rdy; end
      else if (ph == "fi") begin wir = 1; wpc = 1; end
      else if (ph == "dec") begin
        if (op >= 1 && op <= 6) begin wmar = 1; msel = 1; end
        else if (op == 7 || (op == 8 && az)) begin wpc = 1; psel = 1; end
      end
      else if (ph == "oprd") begin mreq = 1; wmbr = rdy; end
      else if (ph == "ex") begin
        wacc = 1;
        asel = (op != 1);
        alu = (op == 4) ? 4'b0001 : (op == 5) ? 4'b1000 : (op == 6) ? 4'b1001 : 4'b0000;
      end
      else if (ph == "opwr") begin mreq = 1; mwe = 1; end
    end
    return {mreq, mwe, wmar, wmbr, wir, wpc, wacc, msel, psel, asel, alu, bit'(ph == "halt"), m_ill};
  endfunction

  task automatic advance(bit rst, bit st, logic [15:0] ir, bit rdy);
    int op = int'(ir[15:12]);
    if (rst) begin ph = "idle"; m_ill = 0; m_ret = 0; return; end
    if (ph == "idle")      begin if (st) ph = "fa"; end
    else if (ph == "fa")   ph = "fm";
    else if (ph == "fm")   begin if (rdy) ph = "fi"; end
    else if (ph == "fi")   ph = "dec";
    else if (ph == "dec") begin
      if (op == 2) ph = "opwr";
      else if (op >= 1 && op <= 6) ph = "oprd";
      else if (op == 7 || op == 8) begin ph = "fa"; m_ret = m_ret + 1; end
      else if (op == 9) ph = "halt";
      else begin ph = "halt"; m_ill = 1; end
    end
    else if (ph == "oprd") begin if (rdy) ph = "ex"; end
    else if (ph == "ex")   begin ph = "fa"; m_ret = m_ret + 1; end
    else if (ph == "opwr") begin if (rdy) begin ph = "fa"; m_ret = m_ret + 1; end end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic cycle(bit rst, bit st, logic [15:0] ir, bit az, bit rdy);
    logic [15:0] exp;
    @(negedge clock);
    reset = rst; start = st; instruction = ir; acc_zero = az; mem_ready = rdy;
    #1;
    exp = expect_out(rst, ir, az, rdy);
    obs = {mem_req, mem_we, write_mar, write_mbr, write_ir, write_pc, write_acc,
           mar_sel, pc_sel, acc_sel, alu_op, halted, illegal};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL outputs phase=%s ir=%h: got %h expected %h", ph, ir, obs, exp);
    end
`ifdef SEQ_RETIRE_COUNT_EN
    check("retired_count", retired_count, m_ret);
`endif
    @(posedge clock);
    advance(rst, st, ir, rdy);
  endtask

  // Runs from the cycle after a FETCH_ADDR until the next FETCH_ADDR (inclusive).
  logic [15:0] dec_obs, exec_obs, first_obs;
  task automatic run_to_fa(logic [15:0] ir, bit az, int store_wait, output int n, output int wr);
    int waited = 0;
    bit rdy;
    n = 0; wr = 0;
    for (int k = 0; k < 60; k++) begin
      rdy = !(ph == "opwr" && waited < store_wait);
      if (ph == "opwr") waited++;
      if (ph == "dec") begin cycle(0, 0, ir, az, rdy); dec_obs = obs; end
      else if (ph == "ex") begin cycle(0, 0, ir, az, rdy); exec_obs = obs; end
      else cycle(0, 0, ir, az, rdy);
      n++;
      if (n == 1) first_obs = obs;
      if (obs[15] && obs[14]) wr++;
      if (obs[13] && !obs[8]) return;
    end
    check("fa_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n, wr;
    logic [15:0] ir;
    bit rst, rdy;

    cycle(1, 0, 16'h0, 0, 1);
    check("reset_mem_req", obs[15], 0);
    cycle(1, 1, 16'h0, 0, 1);
    cycle(0, 0, 16'h0, 0, 1);
    check("idle_outputs", obs, 0);

    // ADD 5, zero-wait memory
    cycle(0, 1, 16'h3005, 0, 1);
    check("idle_start_no_req", obs[15], 0);
    cycle(0, 0, 16'h3005, 0, 1);
    check("fa_write_mar", obs[13], 1);
    check("fa_mem_req", obs[15], 0);
    run_to_fa(16'h3005, 0, 0, n, wr);
    check("fm_mem_req", first_obs[15], 1);
    check("add_latency", n, 6);
    check("add_write_acc", exec_obs[9], 1);
    check("add_acc_sel", exec_obs[6], 1);
    check("add_alu_op", exec_obs[5:2], 4'b0000);

    // STORE with three wait cycles
    run_to_fa(16'h2010, 0, 3, n, wr);
    check("store_req_we_cycles", wr, 4);
    check("store_latency", n, 8);

    // JZ taken, then not taken
    run_to_fa(16'h8020, 1, 0, n, wr);
    check("jz_taken_write_pc", dec_obs[10], 1);
    check("jz_taken_pc_sel", dec_obs[7], 1);
    check("jz_latency", n, 4);
    run_to_fa(16'h8020, 0, 0, n, wr);
    check("jz_not_taken_write_pc", dec_obs[10], 0);
`ifdef SEQ_RETIRE_COUNT_EN
    check("retired_four", retired_count, 32'd4);
`endif

    // Illegal opcode halts and sticks
    for (int k = 0; k < 10 && !obs[1]; k++) cycle(0, 0, 16'hF000, 0, 1);
    check("illegal_halted", obs[1], 1);
    check("illegal_flag", obs[0], 1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 16'hF000, 0, 1);
    check("halted_ignores_start", obs[1:0], 2'b11);
    cycle(1, 0, 16'h0, 0, 1);
    cycle(0, 0, 16'h0, 0, 1);
    check("reset_clears_halt", obs[1:0], 2'b00);

    // Reset during an operand-read wait
    cycle(0, 1, 16'h1007, 0, 1);
    for (int k = 0; k < 10 && ph != "oprd"; k++) cycle(0, 0, 16'h1007, 0, 1);
    cycle(0, 0, 16'h1007, 0, 0);
    check("oprd_wait_req", obs[15], 1);
    cycle(1, 0, 16'h1007, 0, 0);
    check("reset_drops_req", obs[15], 0);
    cycle(0, 0, 16'h1007, 0, 1);
    check("after_reset_idle", obs, 0);

    // Randomized run
    ir = 16'h3001;
    for (int k = 0; k < 4000; k++) begin
      rst = (ph == "halt") ? ($urandom % 8 == 0) : ($urandom % 150 == 0);
      rdy = ($urandom % 4) != 0;
      if (ph == "fi") begin
        ir = 16'($urandom);
        if ($urandom % 20 < 17) ir[15:12] = 4'($urandom_range(1, 8));
      end
      cycle(rst, 1'($urandom), ir, 1'($urandom), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the accumulator computer: PC, MAR, MBR, IR, ACC, ALU and MainMemory.
- Drives every register write enable, the MAR/PC/ACC input muxes, the ALU opcode and the memory request.
- Sits inside Computer alongside the datapath. It holds no architectural state, only the FSM, plus an optional counter.
- Instruction format: IR[15:12] = opcode, IR[11:0] = operand address X.

Parameters:
- DATA_W, 16, width of the instruction input and the datapath.
- ADDR_W, 12, width of the operand field; must be <= DATA_W-4.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching at the current PC.
- instruction  in  DATA_W  current IR contents.
- acc_zero  in  1  ACC == 0, from the datapath.
- mem_ready  in  1  memory has completed the current request.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = write ACC to M[MAR], 0 = read into MBR.
- write_mar, write_mbr, write_ir, write_pc, write_acc  out  1 each  register load enables.
- mar_sel  out  1  MAR source: 0 = PC, 1 = IR[ADDR_W-1:0].
- pc_sel  out  1  PC source: 0 = PC+1, 1 = IR[ADDR_W-1:0].
- acc_sel  out  1  ACC source: 0 = MBR, 1 = ALU result.
- alu_op  out  4  ALU opcode.
- halted  out  1  FSM is in HALTED.
- illegal  out  1  halted because of an undefined opcode.

Behaviour:
- Output decoding:
  - All outputs are Moore decodes of state (and IR in DECODE/EXEC).
  - Exception: write_mbr = mem_ready while in FETCH_MEM or OP_RD.
- Reset: state <= IDLE. In IDLE every output is 0, including alu_op = 0000. Reset in any state, including mid memory wait, returns to IDLE at the next edge and drops mem_req immediately.
- Opcodes:
  - 0x1 LOAD: ACC <= M[X]
  - 0x2 STORE: M[X] <= ACC
  - 0x3 ADD: alu 0000
  - 0x4 SUB: alu 0001
  - 0x5 AND: alu 1000
  - 0x6 OR: alu 1001
  - 0x7 JUMP: PC <= X
  - 0x8 JZ: PC <= X if acc_zero
  - 0x9 HALT
  - All other codes (0x0, 0xA-0xF) are illegal.
- States and transitions:
  - IDLE: go to FETCH_ADDR when start=1, else stay.
  - FETCH_ADDR: write_mar=1, mar_sel=0. Go to FETCH_MEM.
  - FETCH_MEM: mem_req=1, mem_we=0. Stay until mem_ready=1, then go to FETCH_IR.
  - FETCH_IR: write_ir=1, write_pc=1, pc_sel=0. Go to DECODE.
  - DECODE, by opcode:
    - LOAD/STORE/ALU ops: write_mar=1, mar_sel=1. STORE goes to OP_WR; the others go to OP_RD.
    - JUMP: write_pc=1, pc_sel=1, go to FETCH_ADDR.
    - JZ: same as JUMP when acc_zero=1; otherwise no enables, go to FETCH_ADDR.
    - HALT: go to HALTED.
    - Illegal: go to HALTED and set the illegal flag.
  - OP_RD: mem_req=1, mem_we=0. Stay until mem_ready=1, then go to EXEC.
  - EXEC: write_acc=1. acc_sel=0 for LOAD, else 1 with alu_op as mapped above. Go to FETCH_ADDR.
  - OP_WR: mem_req=1, mem_we=1. Stay until mem_ready=1, then go to FETCH_ADDR.
  - HALTED: halted=1. Exit only via reset; start is ignored.
- Illegal flag: registered, set on entry to HALTED from an illegal opcode, cleared only by reset.
- Latency with mem_ready tied high, in cycles from leaving FETCH_ADDR back to FETCH_ADDR:
  - LOAD/ALU ops: 6
  - STORE: 5
  - JUMP/JZ: 4
- Each extra memory wait cycle adds 1.
- mem_ready outside FETCH_MEM/OP_RD/OP_WR is ignored.
- PC+1 wrap-around at 2^ADDR_W is the datapath's concern; the sequencer does not check it.

Optional Feature:
- Macro: SEQ_RETIRE_COUNT_EN.
- Defined:
  - Adds output retired_count (32 bits), reset to 0.
  - Increments by 1 on each transition out of EXEC, OP_WR, or DECODE for JUMP/JZ.
  - Wraps from 0xFFFFFFFF to 0. HALT and illegal opcodes are not counted.
- Undefined: the port and counter are absent, with no other change.

Test Plan:
- Reset, then start=1 with mem_ready high → FETCH_ADDR next cycle; mem_req=1 exactly one cycle later, and 0 during reset and IDLE.
- instruction=0x3005 (ADD 5), zero-wait memory → in EXEC: write_acc=1, acc_sel=1, alu_op=0000; next fetch begins 6 cycles after the first FETCH_ADDR.
- instruction=0x2010 (STORE 0x010), mem_ready delayed 3 cycles → mem_req=1 and mem_we=1 held for 4 cycles, then FETCH_ADDR.
- instruction=0x8020, acc_zero=1 → DECODE asserts write_pc=1 with pc_sel=1. Repeat with acc_zero=0 → no write_pc in DECODE.
- instruction=0xF000 → HALTED with halted=1 and illegal=1; pulsing start has no effect; reset clears both to 0.
- Reset asserted during an OP_RD wait → IDLE next cycle and all enables 0. With SEQ_RETIRE_COUNT_EN defined, 3 retired instructions read retired_count=3.
